// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin APB master sharing the GPIO controller slave port.
// Define GPIO_APB_TIMEOUT_EN to force an error after TIMEOUT_CYCLES ACCESS cycles.
module gpio_apb_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_W-1:0]             paddr,
  output logic                          pwrite,
  output logic                          psel,
  output logic                          penable,
  output logic [DATA_W/8-1:0]           pstrb,
  output logic [DATA_W-1:0]             pwdata,
  input  logic [DATA_W-1:0]             prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             done;
  logic             tmo_hit;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;
  logic              sel_write;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] base,
    input int               off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk downward so the closest requester at or after rr_q wins last.
  always_comb begin
    pick    = rr_q;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_q, k)]) begin
        pick    = wrap_add(rr_q, k);
        any_req = 1'b1;
      end
    end
  end

  assign sel_addr  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(pick)*DATA_W +: DATA_W];
  assign sel_strb  = req_strb[int'(pick)*STRB_W +: STRB_W];
  assign sel_write = req_write[pick];

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && any_req) req_ready[pick] = 1'b1;
  end

`ifdef GPIO_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !pready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (pready || tmo_hit);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SETUP;
          rr_d    = wrap_add(pick, 1);
          gnt_d   = pick;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pstrb     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      rsp_valid <= '0;
      if (state_q == IDLE && any_req) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= sel_addr;
        pwrite  <= sel_write;
        pwdata  <= sel_wdata;
        pstrb   <= sel_write ? sel_strb : '0;
      end
      if (state_q == SETUP) penable <= 1'b1;
      // A timeout completes like pready but reports an error with no data.
      if (done) begin
        psel      <= 1'b0;
        penable   <= 1'b0;
        rsp_valid <= NUM_REQ'(1) << gnt_q;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
  end

endmodule
